// File: rtl/mem_dma_initiator.sv
// mem_dma_initiator: word-copy DMA bus initiator; define DMA_FILL_EN to enable fill mode
module mem_dma_initiator #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             fill_mode,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  output logic [3:0]       m_wstrb,
  output logic             m_we,
  output logic             m_re,
  input  logic             m_ready
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t           r_state, w_next;
  logic [31:0]      r_src, r_dst, r_data, r_fill_value;
  logic [LEN_W-1:0] r_count;
  logic             r_fill, r_err;
  logic             w_fill_req, w_misaligned, w_accept;
  logic [31:0]      w_fill_value;
`ifdef DMA_FILL_EN
  assign w_fill_req   = fill_mode;
  assign w_fill_value = fill_value;
`else
  logic w_unused;
  assign w_unused     = &{1'b0, fill_mode, fill_value};
  assign w_fill_req   = 1'b0;
  assign w_fill_value = 32'h0;
`endif
  assign w_misaligned = |src_addr[1:0] || |dst_addr[1:0];
  assign w_accept     = r_state == IDLE && start;
  assign err          = r_err;
  // next-state decode and bus outputs driven purely from registered state
  always_comb begin
    w_next  = r_state;
    busy    = r_state != IDLE;
    done    = r_state == DONE;
    m_re    = r_state == READ;
    m_we    = r_state == WRITE;
    m_wstrb = r_state == WRITE ? 4'hF : 4'h0;
    m_addr  = r_state == READ ? r_src : r_state == WRITE ? r_dst : 32'h0;
    m_wdata = r_state == WRITE ? (r_fill ? r_fill_value : r_data) : 32'h0;
    case (r_state)
      IDLE:  if (start) w_next = (w_misaligned || len_words == '0) ? DONE : w_fill_req ? WRITE : READ;
      READ:  if (m_ready) w_next = WRITE;
      WRITE: if (m_ready) w_next = r_count == LEN_W'(1) ? DONE : r_fill ? WRITE : READ;
      default: w_next = IDLE;
    endcase
  end
  // state, transfer parameters, pointers and read buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_data       <= '0;
      r_fill_value <= '0;
      r_count      <= '0;
      r_fill       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_src        <= src_addr;
        r_dst        <= dst_addr;
        r_count      <= len_words;
        r_fill       <= w_fill_req;
        r_fill_value <= w_fill_value;
        r_err        <= w_misaligned;
      end
      if (r_state == READ && m_ready) r_data <= m_rdata;
      if (r_state == WRITE && m_ready) begin
        r_src   <= r_src + 32'd4;
        r_dst   <= r_dst + 32'd4;
        r_count <= r_count - LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_dma_initiator.sv
// tb_mem_dma_initiator: vector table plus random transfers checked against a bus-op model
module tb_mem_dma_initiator;
  localparam int LEN_W = 16;
  logic             clk = 0;
  logic             rst, start, fill_mode, m_ready;
  logic [31:0]      src_addr, dst_addr, fill_value, m_rdata;
  logic [LEN_W-1:0] len_words;
  logic             busy, done, err, m_we, m_re;
  logic [31:0]      m_addr, m_wdata;
  logic [3:0]       m_wstrb;
  int total = 0, bad = 0;
  logic [31:0] seed = 32'h5A17_C3E1;

  typedef struct {
    logic [31:0] src, dst;
    logic [15:0] len;
    logic        fm;
    logic [31:0] fv;
    int          stall_pct, first_stall;
    logic        spam;
    int          rst_at;
    logic        exp_err;
    int          exp_done;
  } vec_t;
  typedef struct {
    logic        we;
    logic [31:0] addr, data;
  } op_t;
  vec_t vt[10];

  mem_dma_initiator #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .fill_mode(fill_mode), .fill_value(fill_value),
    .busy(busy), .done(done), .err(err), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_wstrb(m_wstrb), .m_we(m_we), .m_re(m_re), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction
  assign m_rdata = memval(m_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic xfer(input vec_t v);
    op_t q[$];
    op_t o;
    int k = 0, stalls = 0, popped = 0, fs = v.first_stall;
    logic eff_fill, mis, rdy, prev_stall = 0, fin = 0;
    logic [31:0] pa = 0, pd = 0;
    logic pre = 0, pwe = 0;
`ifdef DMA_FILL_EN
    eff_fill = v.fm;
`else
    eff_fill = 1'b0;
`endif
    mis = v.src[1:0] != 2'b0 || v.dst[1:0] != 2'b0;
    if (!mis)
      for (int i = 0; i < int'(v.len); i++) begin
        if (!eff_fill) q.push_back('{1'b0, v.src + 32'(4 * i), 32'h0});
        q.push_back('{1'b1, v.dst + 32'(4 * i), eff_fill ? v.fv : memval(v.src + 32'(4 * i))});
      end
    start = 1; src_addr = v.src; dst_addr = v.dst; len_words = v.len;
    fill_mode = v.fm; fill_value = v.fv; m_ready = 0;
    @(posedge clk); #1;
    while (!fin) begin
      k++;
      start = 0;
      if (v.spam && k == 2) begin
        start = 1; src_addr = ~v.src & 32'hFFFF_FFFC; dst_addr = 32'h0000_0800;
        len_words = 16'd1; fill_mode = ~v.fm; fill_value = 32'h1111_2222;
      end
      if (k > 2000) begin
        chk("timeout", 32'(k), 32'd0);
        fin = 1;
      end else begin
        chk("busy", busy, 1'b1);
        if (prev_stall) begin
          chk("hold_re", m_re, pre);
          chk("hold_we", m_we, pwe);
          chk("hold_addr", m_addr, pa);
          chk("hold_wdata", m_wdata, pd);
        end
        if (done) begin
          chk("done_cycle", 32'(k), 32'(1 + popped + stalls));
          if (v.exp_done >= 0) chk("done_nominal", 32'(k), 32'(v.exp_done));
          chk("err", err, v.exp_err);
          chk("ops_left", 32'(q.size()), 32'd0);
          chk("done_no_req", {m_re, m_we}, 2'b00);
          @(posedge clk); #1;
          chk("done_pulse_len", done, 1'b0);
          chk("idle_busy", busy, 1'b0);
          chk("err_hold", err, v.exp_err);
          fin = 1;
        end else begin
          chk("req_present", m_re | m_we, 1'b1);
          chk("req_excl", m_re & m_we, 1'b0);
          chk("wstrb", m_wstrb, m_we ? 4'hF : 4'h0);
          if (m_re | m_we) begin
            if (q.size() == 0) chk("extra_req", m_addr, 32'hFFFF_FFFF);
            else begin
              o = q[0];
              chk("op_we", m_we, o.we);
              chk("op_addr", m_addr, o.addr);
              if (o.we) chk("op_wdata", m_wdata, o.data);
              else chk("rd_wdata_zero", m_wdata, 32'h0);
            end
            if (v.rst_at == popped) begin
              chk("rst_in_write", m_we, 1'b1);
              rst = 1; m_ready = 1;
              @(posedge clk); #1;
              rst = 0;
              chk("rst_busy", busy, 1'b0);
              chk("rst_we", m_we, 1'b0);
              chk("rst_re", m_re, 1'b0);
              chk("rst_done", done, 1'b0);
              chk("rst_addr", m_addr, 32'h0);
              @(posedge clk); #1;
              chk("rst_no_done", done, 1'b0);
              m_ready = 0;
              return;
            end
            if (fs > 0) begin
              rdy = 0; fs--;
            end else rdy = $urandom_range(99) >= v.stall_pct;
            m_ready = rdy;
            if (rdy) begin
              if (q.size() > 0) void'(q.pop_front());
              popped++;
            end else stalls++;
            prev_stall = !rdy;
            pre = m_re; pwe = m_we; pa = m_addr; pd = m_wdata;
          end
          @(posedge clk); #1;
        end
      end
    end
    m_ready = 0;
    start = 0;
  endtask

  initial begin
    vec_t v;
    rst = 1; start = 0; src_addr = 0; dst_addr = 0; len_words = 0;
    fill_mode = 0; fill_value = 0; m_ready = 1;
    vt[0] = '{32'h0,         32'h100, 16'd4, 1'b0, 32'h0,         0, 0, 1'b0, -1, 1'b0, 9};
    vt[1] = '{32'h0,         32'h100, 16'd0, 1'b0, 32'h0,         0, 0, 1'b0, -1, 1'b0, 1};
    vt[2] = '{32'h2,         32'h100, 16'd4, 1'b0, 32'h0,         0, 0, 1'b0, -1, 1'b1, 1};
    vt[3] = '{32'h40,        32'h101, 16'd1, 1'b0, 32'h0,         0, 0, 1'b0, -1, 1'b1, 1};
    vt[4] = '{32'h40,        32'h140, 16'd2, 1'b0, 32'h0,         0, 3, 1'b0, -1, 1'b0, 8};
    vt[5] = '{32'hFFFF_FFFC, 32'h300, 16'd2, 1'b0, 32'h0,         0, 0, 1'b0, -1, 1'b0, 5};
    vt[6] = '{32'h10,        32'h500, 16'd3, 1'b0, 32'h0,         0, 0, 1'b1, -1, 1'b0, 7};
    vt[7] = '{32'h20,        32'h600, 16'd5, 1'b0, 32'h0,         0, 0, 1'b0,  3, 1'b0, -1};
    vt[8] = '{32'h80,        32'h700, 16'd2, 1'b0, 32'h0,         0, 0, 1'b0, -1, 1'b0, 5};
`ifdef DMA_FILL_EN
    vt[9] = '{32'h0,         32'h200, 16'd3, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0, -1, 1'b0, 4};
`else
    vt[9] = '{32'h0,         32'h200, 16'd3, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0, -1, 1'b0, 7};
`endif
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy0", busy, 1'b0);
    chk("rst_done0", done, 1'b0);
    chk("rst_err0", err, 1'b0);
    chk("rst_re0", m_re, 1'b0);
    chk("rst_we0", m_we, 1'b0);
    chk("rst_wstrb0", m_wstrb, 4'h0);
    chk("rst_addr0", m_addr, 32'h0);
    chk("rst_wdata0", m_wdata, 32'h0);
    for (int i = 0; i < 10; i++) xfer(vt[i]);
    for (int i = 0; i < 25; i++) begin
      v.src = $urandom; v.dst = $urandom;
      if ($urandom_range(5) != 0) v.src[1:0] = 2'b0;
      if ($urandom_range(5) != 0) v.dst[1:0] = 2'b0;
      v.len = 16'($urandom_range(8));
      v.fm = 1'($urandom_range(1));
      v.fv = $urandom;
      v.stall_pct = 30;
      v.first_stall = 0;
      v.spam = 1'($urandom_range(1));
      v.rst_at = -1;
      v.exp_err = v.src[1:0] != 2'b0 || v.dst[1:0] != 2'b0;
      v.exp_done = -1;
      xfer(v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
